// File: rtl/pe_pkg.sv
// Shared constants and width derivations for the parallel multiply-accumulate PE.
package pe_pkg;

  localparam logic MODE_W16 = 1'b0;
  localparam logic MODE_W8  = 1'b1;

  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Adder-tree width: worst-case 2*LANES sub-products of 2*DW bits each.
  function automatic int tree_w(input int dw, input int lanes);
    return 2 * dw + clog2(2 * lanes);
  endfunction

  // Eight guard bits let a group run for 256 worst-case beats before wrapping.
  function automatic int acc_w(input int dw, input int lanes);
    return tree_w(dw, lanes) + 8;
  endfunction

endpackage

// File: rtl/pe_lane_mul.sv
// One lane multiplier: a full DW x DW product, or the sum of two DW/2 x DW/2
// sub-word products when the lane carries packed half-width operands.
module pe_lane_mul
  import pe_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] neuron,
  input  logic signed [DW-1:0] weight,
  input  logic                 mode,
  output logic signed [2*DW:0] prod
);

  localparam int HW = DW / 2;

  logic signed [2*DW-1:0] full;
  logic signed [DW-1:0]   hi;
  logic signed [DW-1:0]   lo;
  logic signed [DW:0]     pair;

  always_comb begin
    full = (2*DW)'(neuron) * (2*DW)'(weight);
    hi   = DW'($signed(neuron[DW-1:HW])) * DW'($signed(weight[DW-1:HW]));
    lo   = DW'($signed(neuron[HW-1:0])) * DW'($signed(weight[HW-1:0]));
    pair = (DW+1)'(hi) + (DW+1)'(lo);
    prod = (mode == MODE_W8) ? (2*DW+1)'(pair) : (2*DW+1)'(full);
  end

endmodule

// File: rtl/param_parallel_pe.sv
// Parallel MAC PE: lane multiply (S1), adder-tree reduce (S2), group accumulate
// with saturation/truncation and ReLU (S3). One result per ctl-delimited group.
module param_parallel_pe
  import pe_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int DW     = 16,
  parameter int ACC_W  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*DW-1:0] neuron,
  input  logic [LANES*DW-1:0] weight,
  input  logic [1:0]          ctl,
  input  logic                vld_i,
  input  logic                mode,
  input  logic                relu_en,
  output logic [ACC_W-1:0]    result,
  output logic                vld_o,
  output logic                ovf_o
);

  localparam int PW = 2 * DW + 1;
  localparam int TW = tree_w(DW, LANES);
  localparam int AW = acc_w(DW, LANES);
  localparam int XW = (AW > ACC_W) ? AW : ACC_W;

  logic mode_q, relu_q;
  logic first_in, mode_eff, relu_eff;

  // The first beat of a group uses its own mode/relu; later beats use the latch.
  assign first_in = vld_i & ctl[CTL_FIRST];
  assign mode_eff = first_in ? mode : mode_q;
  assign relu_eff = first_in ? relu_en : relu_q;

  logic signed [PW-1:0] lane_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    pe_lane_mul #(.DW(DW)) u_mul (
      .neuron (neuron[gi*DW +: DW]),
      .weight (weight[gi*DW +: DW]),
      .mode   (mode_eff),
      .prod   (lane_prod[gi])
    );
  end

  logic signed [PW-1:0] prod1 [LANES];
  logic                 v1, first1, last1, relu1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_W16;
      relu_q <= 1'b0;
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      relu1  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod1[i] <= '0;
    end else begin
      if (first_in) begin
        mode_q <= mode;
        relu_q <= relu_en;
      end
      v1 <= vld_i;
      if (vld_i) begin
        prod1  <= lane_prod;
        first1 <= ctl[CTL_FIRST];
        last1  <= ctl[CTL_LAST];
        relu1  <= relu_eff;
      end
    end
  end

  logic signed [TW-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + TW'(prod1[i]);
  end

  logic signed [TW-1:0] sum2;
  logic                 v2, first2, last2, relu2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum2   <= '0;
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      relu2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum2   <= tree_sum;
        first2 <= first1;
        last2  <= last1;
        relu2  <= relu1;
      end
    end
  end

  logic signed [AW-1:0]  acc, acc_next;
  logic signed [XW-1:0]  a_ext;
  logic [XW-ACC_W:0]     a_top;
  logic                  out_range;
  logic [ACC_W-1:0]      res_c;

  always_comb begin
    acc_next  = first2 ? AW'(sum2) : acc + AW'(sum2);
    a_ext     = XW'(acc_next);
    // Bits from ACC_W-1 upward must all agree for the value to fit signed ACC_W.
    a_top     = a_ext[XW-1:ACC_W-1];
    out_range = !((&a_top) || !(|a_top));
    if (out_range && SAT_EN)
      res_c = a_ext[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      res_c = a_ext[ACC_W-1:0];
    if (relu2 && res_c[ACC_W-1]) res_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
      vld_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (v2) acc <= acc_next;
      vld_o <= v2 & last2;
      ovf_o <= v2 & last2 & out_range;
      if (v2 && last2) result <= res_c;
    end
  end

endmodule

// File: doc/param_parallel_pe.md
Name: param_parallel_pe

Overview:
Parametrised next-generation parallel multiply-accumulate PE for the PE datapath. Takes one beat per cycle of LANES packed neuron and weight words. Multiplies lane-wise, reduces through an adder tree, and accumulates across a ctl-delimited group of beats. Emits one result per group.
Generalises the fixed 32×16-bit PE with:
- a LANES parameter;
- a packed dual-int8 mode;
- optional output saturation with an overflow flag;
- an optional ReLU.

Parameters:
LANES, 32, number of DW-bit lanes per beat; must be a power of two, ≥ 2.
DW, 16, lane width in bits; must be even.
ACC_W, 32, output result width in bits.
SAT_EN, 1, 1 = saturate result to signed ACC_W; 0 = truncate to low ACC_W bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
neuron  in  LANES*DW  packed signed neuron operands; lane i = bits [i*DW +: DW].
weight  in  LANES*DW  packed signed weight operands; same packing as neuron.
ctl  in  2  ctl[0] = first beat of group; ctl[1] = last beat of group.
vld_i  in  1  beat valid; neuron, weight and ctl are ignored when low.
mode  in  1  0 = DW-bit signed lanes; 1 = each lane holds two signed DW/2 sub-words.
relu_en  in  1  1 = clamp negative results to 0.
result  out  ACC_W  signed group result.
vld_o  out  1  one-cycle strobe; result is valid.
ovf_o  out  1  high together with vld_o when the result was saturated or truncated.

Behaviour:
- Reset: result=0, vld_o=0, ovf_o=0. All pipeline valid bits, accumulator and latched mode/relu are cleared. Assertion mid-group aborts the group; no output is produced for it.
- Pipeline is 3 stages, with no backpressure and no stall:
  - S1: lane products registered. Mode 0: LANES signed DW×DW products, 2*DW bits each. Mode 1: 2*LANES signed (DW/2)×(DW/2) products, sign-extended to 2*DW bits.
  - S2: adder-tree sum of all products registered, with first/last flags. Width TW = 2*DW + clog2(2*LANES).
  - S3: accumulator update and output register.
- Latency: vld_o asserts exactly 3 cycles after the cycle in which vld_i=1 and ctl[1]=1.
- Accumulator:
  - Signed, width AW = TW + 8.
  - A valid beat with ctl[0]=1 loads the accumulator with the beat sum; any previous partial is discarded.
  - Other valid beats add the beat sum to the accumulator.
  - Invalid cycles (bubbles) hold the accumulator.
- mode and relu_en are sampled on the first beat (vld_i & ctl[0]) and held for the whole group. Changes mid-group are ignored.
- ctl=2'b11 is a single-beat group; the result is that beat's sum only.
- A valid beat with ctl[1]=1 not preceded by a first beat since reset accumulates onto the current accumulator (0 after reset).
- Back-to-back groups: a first beat in the cycle after a last beat is legal. Both results are emitted on consecutive vld_o strobes.
- Output formation on the last beat, from the final accumulator value A:
  - SAT_EN=1 and A outside the signed ACC_W range: result = 0x7FF..F or 0x800..0, ovf_o=1.
  - SAT_EN=0 and A outside the signed ACC_W range: result = A[ACC_W-1:0], ovf_o=1.
  - Otherwise: result = A, ovf_o=0.
  - ReLU is applied after saturation. When the latched relu_en=1 and result<0, result=0; ovf_o is unchanged.
- result holds its value between strobes; vld_o and ovf_o are low in non-output cycles.

Decomposition:
- Shared package pe_pkg:
  - MODE_W16/MODE_W8 constants;
  - CTL_FIRST=0 and CTL_LAST=1 bit indices;
  - clog2 function;
  - the TW and AW width derivations.
- Sub-module pe_lane_mul: one lane multiplier. Inputs: DW-bit neuron and weight plus mode. Output: the sum of one product (mode 0) or two sub-word products (mode 1), 2*DW+1 bits, combinational.
- Instantiated LANES times inside param_parallel_pe.

Test Plan:
1. LANES=32, mode 0, relu off. Every lane neuron=0x0001, weight=0x0001. 4-beat group (ctl 01,00,00,10) -> single vld_o 3 cycles after the last beat, result=128, ovf_o=0.
2. Mode 1, every byte neuron=0x01, weight=0x02. Single beat ctl=2'b11 -> result=128 (64 sub-products × 2), vld_o 3 cycles later.
3. SAT_EN=1, all lanes 0x7FFF×0x7FFF. Single beat, sum=32×0x3FFF0001 -> result=0x7FFFFFFF, ovf_o=1. Repeat with SAT_EN=0 -> result=0xFFE00020, ovf_o=1.
4. relu_en=1 latched on the first beat, then dropped mid-group. Lanes 0x0001×0xFFFF over 2 beats -> result=0, not -64. Repeat with relu_en=0 at the first beat -> result=0xFFFFFFC0.
5. 3-beat group with vld_i=0 bubbles between beats, immediately followed by a back-to-back single-beat group -> two correct results on separate strobes, with no corruption of the accumulator by the bubbles.
6. rst_n pulsed low mid-group, then a fresh 2-beat group of all-ones operands -> no output for the aborted group; new result=64, outputs 0 during reset.
